note_midi_sequencer: RTL and testbench

NOTE_MIDI_SEQUENCER -- requirements
Module: note_midi_sequencer

---
 rtl/note_midi_sequencer.sv | 135 +++++++++++++
 tb/tb_note_midi_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_midi_sequencer.sv
// Turns a one-hot semitone vector into MIDI note-off/note-on byte streams
// over a valid/ready byte interface, keeping at most one note sounding.
module note_midi_sequencer #(
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned BASE_NOTE = 60,
  parameter int unsigned VELOCITY  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_note,
  input  logic        i_enable,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_active,
  output logic [6:0]  o_active_key,
  output logic [15:0] o_msg_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    OFF_ST,
    OFF_KEY,
    OFF_VEL,
    ON_ST,
    ON_KEY,
    ON_VEL
  } state_t;

  localparam logic [7:0] NOTE_OFF_BYTE = 8'h80 | 8'(CHANNEL);
  localparam logic [7:0] NOTE_ON_BYTE  = 8'h90 | 8'(CHANNEL);
  localparam logic [7:0] VEL_BYTE      = 8'(VELOCITY);

  state_t      state_reg, state_next;
  logic [6:0]  key_reg;
  logic        tgt_note_reg;
  logic        active_reg;
  logic [6:0]  active_key_reg;
  logic [15:0] msg_cnt_reg;

  logic [6:0]  bit_key [12];
  logic        tgt_note;
  logic [6:0]  tgt_key;
  logic        tgt_change;

  // Bit 11 is C, so bit index i maps to semitone 11-i above BASE_NOTE.
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_key
      assign bit_key[gi] = 7'(BASE_NOTE + 11 - gi);
    end
  endgenerate

  always_comb begin
    tgt_note = 1'b0;
    tgt_key  = 7'd0;
    if (i_enable && (i_note != 12'd0) && ((i_note & (i_note - 12'd1)) == 12'd0)) begin
      tgt_note = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (i_note[i]) tgt_key = bit_key[i];
      end
    end
  end

  // "No note" carries key 0, matching the cleared active key.
  assign tgt_change = (tgt_note != active_reg) || (tgt_key != active_key_reg);

  always_comb begin
    state_next = state_reg;
    o_byte     = 8'h00;
    case (state_reg)
      IDLE: begin
        if (tgt_change) state_next = active_reg ? OFF_ST : ON_ST;
      end
      OFF_ST: begin
        o_byte = NOTE_OFF_BYTE;
        if (i_ready) state_next = OFF_KEY;
      end
      OFF_KEY: begin
        o_byte = {1'b0, active_key_reg};
        if (i_ready) state_next = OFF_VEL;
      end
      OFF_VEL: begin
        o_byte = 8'h00;
        if (i_ready) state_next = tgt_note_reg ? ON_ST : IDLE;
      end
      ON_ST: begin
        o_byte = NOTE_ON_BYTE;
        if (i_ready) state_next = ON_KEY;
      end
      ON_KEY: begin
        o_byte = {1'b0, key_reg};
        if (i_ready) state_next = ON_VEL;
      end
      ON_VEL: begin
        o_byte = VEL_BYTE;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      key_reg        <= 7'd0;
      tgt_note_reg   <= 1'b0;
      active_reg     <= 1'b0;
      active_key_reg <= 7'd0;
      msg_cnt_reg    <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && tgt_change) begin
        key_reg      <= tgt_key;
        tgt_note_reg <= tgt_note;
      end
      if (i_ready && state_reg == OFF_VEL) begin
        active_reg     <= 1'b0;
        active_key_reg <= 7'd0;
        msg_cnt_reg    <= msg_cnt_reg + 16'd1;
      end
      if (i_ready && state_reg == ON_VEL) begin
        active_reg     <= 1'b1;
        active_key_reg <= key_reg;
        msg_cnt_reg    <= msg_cnt_reg + 16'd1;
      end
    end
  end

  assign o_valid      = (state_reg != IDLE);
  assign o_active     = active_reg;
  assign o_active_key = active_key_reg;
  assign o_msg_cnt    = msg_cnt_reg;

endmodule

// File: tb/tb_note_midi_sequencer.sv
// Randomized scoreboard bench: expected MIDI bytes are queued from a note-level
// model and a negedge monitor pops them whenever a byte is handed over.
module tb_note_midi_sequencer;

  localparam int CHANNEL   = 0;
  localparam int BASE_NOTE = 60;
  localparam int VELOCITY  = 100;
  localparam int NUM_ITER  = 150;
  localparam int MAX_WAIT  = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] i_note = 12'd0;
  logic        i_enable = 1'b0;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_active;
  logic [6:0]  o_active_key;
  logic [15:0] o_msg_cnt;

  note_midi_sequencer #(
    .CHANNEL  (CHANNEL),
    .BASE_NOTE(BASE_NOTE),
    .VELOCITY (VELOCITY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_note      (i_note),
    .i_enable    (i_enable),
    .o_byte      (o_byte),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_active    (o_active),
    .o_active_key(o_active_key),
    .o_msg_cnt   (o_msg_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  m_active = 1'b0;
  int  m_key = 0;
  int  m_cnt = 0;

  // Sounding key for an input pattern, or -1 for "no note".
  function automatic int decode(input logic [11:0] n, input logic en);
    if (!en || $countones(n) != 1) return -1;
    for (int i = 0; i < 12; i++) begin
      if (n[i]) return BASE_NOTE + 11 - i;
    end
    return -1;
  endfunction

  task automatic expect_target(input logic [11:0] n, input logic en);
    int  k;
    bit  t_active;
    int  t_key;
    k        = decode(n, en);
    t_active = (k >= 0);
    t_key    = t_active ? k : 0;
    if (t_active == m_active && t_key == m_key) return;
    if (m_active) begin
      sb.push_back(8'h80 | 8'(CHANNEL));
      sb.push_back(8'(m_key));
      sb.push_back(8'h00);
      m_cnt++;
    end
    if (t_active) begin
      sb.push_back(8'h90 | 8'(CHANNEL));
      sb.push_back(8'(t_key));
      sb.push_back(8'(VELOCITY));
      m_cnt++;
    end
    m_active = t_active;
    m_key    = t_key;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pick_target(output logic [11:0] n, output logic en);
    int r, a, b;
    r = $urandom_range(0, 99);
    a = $urandom_range(0, 11);
    n = 12'd1 << a;
    en = 1'b1;
    if (r >= 50 && r < 62) begin
      n = 12'd0;
    end else if (r >= 62 && r < 77) begin
      b = (a + 1 + $urandom_range(0, 10)) % 12;
      n = n | (12'd1 << b);
    end else if (r >= 77 && r < 90) begin
      en = 1'b0;
    end else if (r >= 90) begin
      n  = i_note;
      en = i_enable;
    end
  endtask

  // Monitor: a byte is handed over on the next rising edge when valid and ready.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (o_valid && i_ready && !rst) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got %02h expected none", o_byte);
      end else begin
        exp = sb.pop_front();
        $display("byte %02h expected %02h", o_byte, exp);
        if (o_byte !== exp) begin
          errors++;
          $display("FAIL byte got %02h expected %02h", o_byte, exp);
        end
      end
    end else if (!o_valid) begin
      checks++;
      if (o_byte !== 8'h00) begin
        errors++;
        $display("FAIL idle_byte got %02h expected 00", o_byte);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] f_note;
    logic        f_en;
    int          cyc;
    bit          abort;
    abort = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_active", int'(o_active), 0);
    check("rst_key", int'(o_active_key), 0);
    check("rst_cnt", int'(o_msg_cnt), 0);

    @(posedge clk); #1;
    rst = 1'b0; i_note = 12'h800; i_enable = 1'b1; i_ready = 1'b1;
    expect_target(i_note, i_enable);
    @(negedge clk);
    check("latency_idle", int'(o_valid), 0);
    @(negedge clk);
    check("latency_valid", int'(o_valid), 1);

    for (int k = 0; k < NUM_ITER && !abort; k++) begin
      if (k > 0) expect_target(i_note, i_enable);
      if (k == 0) begin
        f_note = 12'h004; f_en = 1'b1;
      end else begin
        pick_target(f_note, f_en);
      end
      cyc = 0;
      if (sb.size() == 0) begin
        @(posedge clk); #1;
        i_note = f_note; i_enable = f_en;
      end
      while (sb.size() != 0) begin
        @(posedge clk); #1;
        cyc++;
        i_ready = (k < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        // Inputs may wander mid-message but settle before the FSM can idle.
        if (k >= 2 && sb.size() > 2 && $urandom_range(0, 1) == 1) begin
          i_note = 12'($urandom); i_enable = 1'($urandom);
        end else begin
          i_note = f_note; i_enable = f_en;
        end
        if (cyc > MAX_WAIT) begin
          check("message_timeout", cyc, MAX_WAIT);
          abort = 1'b1;
          break;
        end
      end
      @(negedge clk);
      check("active", int'(o_active), int'(m_active));
      check("active_key", int'(o_active_key), m_key);
      check("msg_cnt", int'(o_msg_cnt), m_cnt % 65536);
    end

    if (!abort) begin
      @(posedge clk); #1;
      rst = 1'b1; i_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst2_valid", int'(o_valid), 0);
      check("rst2_active", int'(o_active), 0);
      check("rst2_cnt", int'(o_msg_cnt), 0);
      sb.delete();
      m_active = 1'b0; m_key = 0; m_cnt = 0;

      @(posedge clk); #1;
      rst = 1'b0; i_note = 12'h800; i_enable = 1'b1; i_ready = 1'b1;
      expect_target(i_note, i_enable);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; i_ready = 1'b0;
      check("midmsg_popped", sb.size(), 2);
      sb.delete();
      m_active = 1'b0; m_key = 0; m_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", int'(o_valid), 0);
      check("midrst_byte", int'(o_byte), 0);
      check("midrst_active", int'(o_active), 0);
      check("midrst_key", int'(o_active_key), 0);
      check("midrst_cnt", int'(o_msg_cnt), 0);

      @(posedge clk); #1;
      rst = 1'b0; i_note = 12'h000; i_enable = 1'b1; i_ready = 1'b1;
      expect_target(i_note, i_enable);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("post_rst_valid", int'(o_valid), 0);
      check("post_rst_active", int'(o_active), 0);
      check("post_rst_cnt", int'(o_msg_cnt), 0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
